// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_ctrl_outputs.sv
// Combinational state-to-output decode for the MIPS main controller.
module mips_ctrl_outputs
  import mips_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  input  logic       taken_i,
  input  logic       decode_illegal_i,
  output logic       mem_req_o,
  output logic       iord_o,
  output logic       memwrite_o,
  output logic       irwrite_o,
  output logic       regwrite_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] pcsrc_o,
  output logic [1:0] aluop_o,
  output logic       pcen_o,
  output logic       illegal_op_o
);

  state_e state;
  logic   pcwrite;
  logic   branch;

  assign state = state_e'(state_i);

  always_comb begin
    mem_req_o    = 1'b0;
    iord_o       = 1'b0;
    memwrite_o   = 1'b0;
    irwrite_o    = 1'b0;
    regwrite_o   = 1'b0;
    regdst_o     = 1'b0;
    memtoreg_o   = 1'b0;
    alusrca_o    = 1'b0;
    alusrcb_o    = SRCB_REG;
    pcsrc_o      = PCSRC_ALURES;
    aluop_o      = ALUOP_ADD;
    illegal_op_o = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req_o = 1'b1;
        alusrcb_o = SRCB_FOUR;
        irwrite_o = mem_ready_i;
        pcwrite   = mem_ready_i;
      end
      S_DECODE: begin
        alusrcb_o    = SRCB_IMMSH2;
        illegal_op_o = decode_illegal_i;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
      end
      S_MEMWB: begin
        regwrite_o = 1'b1;
        memtoreg_o = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_o  = 1'b1;
        iord_o     = 1'b1;
        memwrite_o = 1'b1;
      end
      S_EXECUTE: begin
        alusrca_o = 1'b1;
        aluop_o   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite_o = 1'b1;
        regdst_o   = 1'b1;
      end
      S_BRANCH: begin
        alusrca_o = 1'b1;
        aluop_o   = ALUOP_SUB;
        pcsrc_o   = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      S_ADDIWB: regwrite_o = 1'b1;
      S_JUMP: begin
        pcsrc_o = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen_o = pcwrite | (branch & taken_i);

endmodule

// File: rtl/mips_main_controller.sv
// Multicycle MIPS main control FSM: state register, reset idle counter, next-state logic.
// Optional macro MIPS_BNE_EN adds BNE support through the BRANCH state.
module mips_main_controller
  import mips_pkg::*;
#(
  parameter int unsigned RESET_IDLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       pcen,
  output logic       illegal_op
);

  localparam logic [3:0] IDLE_LAST = 4'(RESET_IDLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic       decode_illegal;
  logic       taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

`ifdef MIPS_BNE_EN
  // Branch polarity latched in DECODE: 1 means BNE (taken on ~zero).
  logic bne_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bne_q <= 1'b0;
    else if (state_q == S_DECODE)
      bne_q <= (opcode == OP_BNE);
  end

  assign taken = zero ^ bne_q;
`else
  assign taken = zero;
`endif

  always_comb begin
    state_d        = state_q;
    idle_cnt_d     = idle_cnt_q;
    decode_illegal = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (idle_cnt_q == IDLE_LAST) begin
          state_d    = S_FETCH;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 4'd1;
        end
      end
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d        = S_FETCH;
            decode_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEX:   state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  mips_ctrl_outputs u_outputs (
    .state_i          (state_q),
    .mem_ready_i      (mem_ready),
    .taken_i          (taken),
    .decode_illegal_i (decode_illegal),
    .mem_req_o        (mem_req),
    .iord_o           (iord),
    .memwrite_o       (memwrite),
    .irwrite_o        (irwrite),
    .regwrite_o       (regwrite),
    .regdst_o         (regdst),
    .memtoreg_o       (memtoreg),
    .alusrca_o        (alusrca),
    .alusrcb_o        (alusrcb),
    .pcsrc_o          (pcsrc),
    .aluop_o          (aluop),
    .pcen_o           (pcen),
    .illegal_op_o     (illegal_op)
  );

endmodule
